alu_issue: RTL
==============

Name: alu_issue

Overview:
- Decode/issue stage that drives the core ALU's input interface: operands_a, operands_b, alu_op, shamt, invert.
- Accepts one fetched RV32I instruction per cycle, together with its register-file read data and PC, over a valid/ready handshake.
- Decodes OP, OP-IMM, LUI and AUIPC into ALU controls.
- Presents the result through a registered 2-entry skid buffer to the execute stage. Input ready is a registered signal, which breaks the combinational path from the execute stage back to fetch.

Parameters:
- DATA_WIDTH, 32, operand width.
- SHAMT_WIDTH, 5, shift-amount width.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all buffered entries
- instr_i  in  32  instruction word
- pc_i  in  DATA_WIDTH  PC of instr_i
- rs1_data_i  in  DATA_WIDTH  register-file read of instr_i[19:15]
- rs2_data_i  in  DATA_WIDTH  register-file read of instr_i[24:20]
- instr_valid_i  in  1  upstream valid
- instr_ready_o  out  1  upstream ready (registered)
- ex_valid_o  out  1  execute-side valid
- ex_ready_i  in  1  execute-side ready
- operands_a_o  out  DATA_WIDTH  ALU operand a
- operands_b_o  out  DATA_WIDTH  ALU operand b
- alu_op_o  out  5  core_pkg ALU opcode
- shamt_o  out  SHAMT_WIDTH  shift amount
- invert_o  out  1  subtract / arithmetic-shift select
- rd_o  out  5  destination register
- illegal_o  out  1  entry carries an unsupported instruction

Behaviour:
- Transfers: input transfer = instr_valid_i & instr_ready_o; output transfer = ex_valid_o & ex_ready_i.
- Decode (combinational, captured on input transfer); immediates are sign-extended I-type, except the U-type forms noted:
  - ADD/SUB: op ADD, a=rs1, b=rs2 or imm; invert=1 only for OP with funct7[5]=1 (SUB).
  - AND/OR/XOR(+I): matching op, a=rs1, b=rs2 or imm, invert=0.
  - SLL/SLLI: op SLL, b=rs1, shamt=rs2[4:0] (OP) or instr[24:20] (OP-IMM), a=0. The ALU shifts operand b.
  - SRL/SRA(+I): op SRL, b=rs1, shamt as for SLL; invert=funct7[5].
  - SLT/SLTU(+I): op SLT/SLTU, a=rs1, b=rs2 or imm, invert=1.
  - LUI: op ADD, a=0, b={instr[31:12],12'b0}.
  - AUIPC: op ADD, a=pc_i, b={instr[31:12],12'b0}.
  - Any other opcode, or a bad funct7 (OP: funct7 not 0000000, and not 0100000 for ADD/SRL; OP-IMM shifts: funct7 not 0000000/0100000 as applicable): illegal=1, op ADD, a=b=0, shamt=0, invert=0, rd=0. The entry still flows through the buffer.
- Buffer FSM states:
  - EMPTY: ex_valid_o=0, instr_ready_o=1. Input transfer → ONE (loads output register).
  - ONE: ex_valid_o=1, instr_ready_o=1.
    - Input and output transfer together → ONE (output register reloaded).
    - Input only → FULL (entry goes to skid register).
    - Output only → EMPTY.
  - FULL: ex_valid_o=1, instr_ready_o=0.
    - Output transfer → ONE; skid entry moves to the output register.
    - No new input is accepted while FULL.
- Latency: one cycle from input transfer to ex_valid_o when EMPTY. Sustained throughput is one per cycle while ex_ready_i=1.
- Output payload is held stable while ex_valid_o=1 and ex_ready_i=0.
- flush_i: next state EMPTY and the input transfer in that cycle is dropped. Flush has priority over all transfers.
- Reset: state EMPTY; instr_ready_o=0 while rst_ni=0, then 1 from the first cycle after release. ex_valid_o=0, every payload output=0, alu_op_o=ADD. A reset asserted mid-stream discards all entries.

Optional Feature:
- Macro: AURIGA_ISSUE_PERF_EN.
- Defined: adds outputs issued_cnt_o[31:0] and stall_cnt_o[31:0].
  - issued_cnt_o increments on each output transfer.
  - stall_cnt_o increments each cycle with instr_valid_i=1 and instr_ready_o=0.
  - Both wrap modulo 2^32, reset to 0 and are unaffected by flush.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- core_pkg holds:
  - ALU opcode constants, reused unchanged.
  - RV32I opcode constants: OPC_OP=0110011, OPC_OP_IMM=0010011, OPC_LUI=0110111, OPC_AUIPC=0010111.
  - Packed struct issue_pkt_t {a, b, alu_op, shamt, invert, rd, illegal}.
- One sub-module, issue_decode: a purely combinational decoder from instr/pc/rs data to issue_pkt_t. alu_issue instantiates it plus the skid-buffer FSM.

Test Plan:
- addi x1,x0,5 (0x00500093), rs1=0, ex_ready_i=1 → next cycle ex_valid_o=1, op ADD, a=0, b=5, invert=0, rd=1.
- sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3 → op ADD, a=10, b=3, invert=1, rd=3.
- srai x5,x6,3 (0x40335293), rs1=0x80000000 → op SRL, b=0x80000000, shamt=3, invert=1, rd=5. Also lui x7,0x12345 (0x123453B7) → a=0, b=0x12345000.
- Backpressure: ex_ready_i=0 with 3 back-to-back valid instructions:
  - Accepts 2, then instr_ready_o=0; the third is held upstream.
  - Output stays on the first instruction.
  - Releasing ex_ready_i drains them in order, one per cycle, with no loss or duplication.
- Flush in FULL state with instr_valid_i=1 → next cycle ex_valid_o=0, instr_ready_o=1; nothing from before the flush is issued. Reset asserted in FULL gives the same empty result.
- Opcode 0x0000007F → illegal_o=1, a=b=0, op ADD. Back-to-back random legal stream with ex_ready_i=1 → one issue per cycle, matching a reference decoder model.

Source files
------------

// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core types and constants: ALU opcodes, RV32I major
//               opcodes, buffer state encoding and the issue packet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

   localparam int XLEN    = 32;
   localparam int SHAMT_W = 5;

   // ALU opcode encoding consumed by the core ALU
   typedef logic [4:0] alu_op_t;
   localparam alu_op_t ALU_ADD  = 5'd0;
   localparam alu_op_t ALU_SLL  = 5'd1;
   localparam alu_op_t ALU_SLT  = 5'd2;
   localparam alu_op_t ALU_SLTU = 5'd3;
   localparam alu_op_t ALU_XOR  = 5'd4;
   localparam alu_op_t ALU_SRL  = 5'd5;
   localparam alu_op_t ALU_OR   = 5'd6;
   localparam alu_op_t ALU_AND  = 5'd7;

   // RV32I major opcodes handled by the issue stage
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   // funct7 values that are legal for the supported R-type/shift forms
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Skid-buffer occupancy
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } buf_state_e;

   // One decoded entry as it travels through the skid buffer
   typedef struct packed {
      logic [XLEN-1:0]    a;
      logic [XLEN-1:0]    b;
      alu_op_t            alu_op;
      logic [SHAMT_W-1:0] shamt;
      logic               invert;
      logic [4:0]         rd;
      logic               illegal;
   } issue_pkt_t;

endpackage

`default_nettype wire

// File: rtl/issue_decode.sv
// ============================================================================
// Module      : issue_decode
// Description : Purely combinational RV32I decoder for OP, OP-IMM, LUI and
//               AUIPC into ALU controls. Anything else becomes an illegal
//               entry with zeroed operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_decode
   import core_pkg::*;
(
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output issue_pkt_t      pkt_o
);

   logic [6:0]         opcode;
   logic [2:0]         funct3;
   logic [6:0]         funct7;
   logic [XLEN-1:0]    imm_i;
   logic [XLEN-1:0]    imm_u;
   logic               is_op;
   logic [XLEN-1:0]    src2;
   logic [SHAMT_W-1:0] shamt_src;
   logic               f7_zero;
   logic               f7_alt;
   logic               w_unused_rs_idx;

   assign opcode    = instr_i[6:0];
   assign funct3    = instr_i[14:12];
   assign funct7    = instr_i[31:25];
   assign imm_i     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_u     = {instr_i[31:12], 12'b0};
   assign is_op     = (opcode == OPC_OP);
   assign src2      = is_op ? rs2_data_i : imm_i;
   assign shamt_src = is_op ? rs2_data_i[SHAMT_W-1:0] : instr_i[24:20];
   assign f7_zero   = (funct7 == F7_ZERO);
   assign f7_alt    = (funct7 == F7_ALT);

   // Register indices are resolved upstream; only their data arrives here
   assign w_unused_rs_idx = ^instr_i[19:15];

   // Decode into a packet; illegal encodings collapse to a zero ADD
   always_comb begin
      logic legal;
      legal  = 1'b0;
      pkt_o  = '0;
      pkt_o.alu_op = ALU_ADD;
      unique case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            pkt_o.a = rs1_data_i;
            pkt_o.b = src2;
            case (funct3)
               3'b000: begin
                  legal        = !is_op || f7_zero || f7_alt;
                  pkt_o.alu_op = ALU_ADD;
                  pkt_o.invert = is_op && funct7[5];
               end
               3'b001: begin
                  // Shifter operates on operand b; a is unused and held at 0
                  legal        = f7_zero;
                  pkt_o.alu_op = ALU_SLL;
                  pkt_o.a      = '0;
                  pkt_o.b      = rs1_data_i;
                  pkt_o.shamt  = shamt_src;
               end
               3'b101: begin
                  legal        = f7_zero || f7_alt;
                  pkt_o.alu_op = ALU_SRL;
                  pkt_o.a      = '0;
                  pkt_o.b      = rs1_data_i;
                  pkt_o.shamt  = shamt_src;
                  pkt_o.invert = funct7[5];
               end
               3'b010: begin
                  legal        = !is_op || f7_zero;
                  pkt_o.alu_op = ALU_SLT;
                  pkt_o.invert = 1'b1;
               end
               3'b011: begin
                  legal        = !is_op || f7_zero;
                  pkt_o.alu_op = ALU_SLTU;
                  pkt_o.invert = 1'b1;
               end
               3'b100: begin
                  legal        = !is_op || f7_zero;
                  pkt_o.alu_op = ALU_XOR;
               end
               3'b110: begin
                  legal        = !is_op || f7_zero;
                  pkt_o.alu_op = ALU_OR;
               end
               default: begin
                  legal        = !is_op || f7_zero;
                  pkt_o.alu_op = ALU_AND;
               end
            endcase
         end
         OPC_LUI: begin
            legal   = 1'b1;
            pkt_o.a = '0;
            pkt_o.b = imm_u;
         end
         OPC_AUIPC: begin
            legal   = 1'b1;
            pkt_o.a = pc_i;
            pkt_o.b = imm_u;
         end
         default: legal = 1'b0;
      endcase

      if (legal) begin
         pkt_o.rd = instr_i[11:7];
      end else begin
         pkt_o         = '0;
         pkt_o.alu_op  = ALU_ADD;
         pkt_o.illegal = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_issue.sv
// ============================================================================
// Module      : alu_issue
// Description : Decode/issue stage feeding the core ALU. Accepts one RV32I
//               instruction per cycle and presents decoded ALU controls via
//               a registered 2-entry skid buffer with registered input ready.
// Options     : AURIGA_ISSUE_PERF_EN adds issued_cnt_o / stall_cnt_o.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue
   import core_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic [31:0]            instr_i,
   input  logic [DATA_WIDTH-1:0]  pc_i,
   input  logic [DATA_WIDTH-1:0]  rs1_data_i,
   input  logic [DATA_WIDTH-1:0]  rs2_data_i,
   input  logic                   instr_valid_i,
   output logic                   instr_ready_o,
   output logic                   ex_valid_o,
   input  logic                   ex_ready_i,
   output logic [DATA_WIDTH-1:0]  operands_a_o,
   output logic [DATA_WIDTH-1:0]  operands_b_o,
   output logic [4:0]             alu_op_o,
   output logic [SHAMT_WIDTH-1:0] shamt_o,
   output logic                   invert_o,
   output logic [4:0]             rd_o,
   output logic                   illegal_o
`ifdef AURIGA_ISSUE_PERF_EN
   ,
   output logic [31:0]            issued_cnt_o,
   output logic [31:0]            stall_cnt_o
`endif
);

   // The packet layout is fixed by the shared package
   if (DATA_WIDTH != XLEN || SHAMT_WIDTH != SHAMT_W) begin : g_width_check
      $error("alu_issue: DATA_WIDTH/SHAMT_WIDTH must match core_pkg XLEN/SHAMT_W");
   end

   buf_state_e state_q, state_d;
   issue_pkt_t out_q, out_d;
   issue_pkt_t skid_q, skid_d;
   issue_pkt_t dec_pkt;
   logic       ready_q, ready_d;
   logic       in_xfer;
   logic       out_xfer;

   issue_decode u_decode (
      .instr_i    (instr_i),
      .pc_i       (pc_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .pkt_o      (dec_pkt)
   );

   assign ex_valid_o    = (state_q != ST_EMPTY);
   assign instr_ready_o = ready_q;
   assign in_xfer       = instr_valid_i & ready_q;
   assign out_xfer      = ex_valid_o & ex_ready_i;

   // Skid-buffer next state and payload steering; flush overrides everything
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               out_d   = dec_pkt;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               out_d   = dec_pkt;
            end else if (in_xfer) begin
               skid_d  = dec_pkt;
               state_d = ST_FULL;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush_i) begin
         state_d = ST_EMPTY;
      end
      // Ready is registered from the upcoming occupancy so fetch never sees
      // a combinational path from ex_ready_i
      ready_d = (state_d != ST_FULL);
   end

   // Buffer state, registered ready and payload registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_EMPTY;
         ready_q <= 1'b0;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

   assign operands_a_o = out_q.a;
   assign operands_b_o = out_q.b;
   assign alu_op_o     = out_q.alu_op;
   assign shamt_o      = out_q.shamt;
   assign invert_o     = out_q.invert;
   assign rd_o         = out_q.rd;
   assign illegal_o    = out_q.illegal;

`ifdef AURIGA_ISSUE_PERF_EN
   logic [31:0] issued_cnt_q;
   logic [31:0] stall_cnt_q;

   // Free-running event counters; flush deliberately does not clear them
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issued_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         if (out_xfer) begin
            issued_cnt_q <= issued_cnt_q + 32'd1;
         end
         if (instr_valid_i && !ready_q) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign issued_cnt_o = issued_cnt_q;
   assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

`default_nettype wire
